spi_rgbw_frame_decoder: RTL and testbench

//  Sits directly downstream of the SPI byte receiver and consumes its rdy/data byte stream.

---
 rtl/spi_rgbw_frame_decoder.sv | 219 +++++++++++++++++++++
 tb/tb_spi_rgbw_frame_decoder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/spi_rgbw_frame_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : spi_rgbw_frame_decoder
//  Brief    : Parses header+payload command frames from the SPI byte receiver
//             and commits complete frames atomically into the RGBW/intensity
//             registers that feed the PWM stage. Malformed frames (bad header,
//             chip-select abort, inter-byte timeout) are dropped and counted.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_rgbw_frame_decoder #(
  parameter int         TIMEOUT_CYCLES = 65535,
  parameter logic [7:0] INTENSITY_RST  = 8'hFF,
  parameter logic [3:0] SYNC_NIBBLE    = 4'hA
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       rdy,
  input  logic [7:0] data,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic [7:0] white,
  output logic [7:0] intensity,
  output logic       update,
  output logic       frame_err,
  output logic [7:0] err_count,
  output logic       busy
);

  // Timer compare value, one bit wider than the timer so timer+1 never wraps.
  localparam logic [16:0] c_timeout = 17'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_COMMIT  = 2'd2,
    ST_ABORT   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_rdy_q;
  logic        w_byte_ev;
  logic [3:0]  r_op;
  logic [2:0]  r_idx;
  logic [15:0] r_timer;
  logic [7:0]  r_shadow [0:4];
  logic        r_hdr_err;

  logic [2:0]  w_hdr_len;
  logic [2:0]  w_op_len;
  logic        w_hdr_ok;
  logic        w_last;
  logic        w_timer_hit;
  logic        w_load_hdr;
  logic        w_hdr_bad;
  logic        w_store;
  logic        w_timer_tick;

  // Payload length for an opcode; zero marks an invalid opcode.
  function automatic logic [2:0] payload_len(input logic [3:0] op);
    case (op)
      4'd1:                     payload_len = 3'd4;
      4'd2, 4'd3, 4'd4, 4'd5,
      4'd6:                     payload_len = 3'd1;
      4'd7:                     payload_len = 3'd5;
      default:                  payload_len = 3'd0;
    endcase
  endfunction

  assign w_byte_ev   = rdy & ~r_rdy_q;
  assign w_hdr_len   = payload_len(data[3:0]);
  assign w_op_len    = payload_len(r_op);
  assign w_hdr_ok    = (data[7:4] == SYNC_NIBBLE) && (w_hdr_len != 3'd0);
  assign w_last      = (r_idx == (w_op_len - 3'd1));
  assign w_timer_hit = (({1'b0, r_timer} + 17'd1) == c_timeout);

  // Edge detector on rdy so a level held for several cycles yields one byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rdy_q <= 1'b0;
    else        r_rdy_q <= rdy;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic, datapath strobes and status outputs.
  always_comb begin
    w_state_next = r_state;
    w_load_hdr   = 1'b0;
    w_hdr_bad    = 1'b0;
    w_store      = 1'b0;
    w_timer_tick = 1'b0;
    update       = 1'b0;
    frame_err    = r_hdr_err;
    busy         = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        // Bytes seen while the bus is deselected are ignored in IDLE.
        if (w_byte_ev && !cs) begin
          if (w_hdr_ok) begin
            w_load_hdr   = 1'b1;
            w_state_next = ST_PAYLOAD;
          end else begin
            w_hdr_bad = 1'b1;
          end
        end
      end
      ST_PAYLOAD: begin
        // Deselect takes priority over a byte arriving in the same cycle.
        if (cs) begin
          w_state_next = ST_ABORT;
        end else if (w_byte_ev) begin
          w_store = 1'b1;
          if (w_last) w_state_next = ST_COMMIT;
        end else if (w_timer_hit) begin
          w_state_next = ST_ABORT;
        end else begin
          w_timer_tick = 1'b1;
        end
      end
      ST_COMMIT: begin
        update       = 1'b1;
        w_state_next = ST_IDLE;
      end
      ST_ABORT: begin
        frame_err    = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Opcode latch, payload index and inter-byte timer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op    <= 4'd0;
      r_idx   <= 3'd0;
      r_timer <= 16'd0;
    end else if (w_load_hdr) begin
      r_op    <= data[3:0];
      r_idx   <= 3'd0;
      r_timer <= 16'd0;
    end else if (w_store) begin
      r_idx   <= r_idx + 3'd1;
      r_timer <= 16'd0;
    end else if (w_timer_tick) begin
      r_timer <= r_timer + 16'd1;
    end
  end

  // Shadow bytes collect the payload; an aborted frame wipes them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 5; i++) r_shadow[i] <= 8'd0;
    end else if (w_store) begin
      for (int i = 0; i < 5; i++)
        if (r_idx == 3'(i)) r_shadow[i] <= data;
    end else if (r_state == ST_ABORT) begin
      for (int i = 0; i < 5; i++) r_shadow[i] <= 8'd0;
    end
  end

  // Discarded-frame bookkeeping: header error pulse and saturating counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hdr_err <= 1'b0;
      err_count <= 8'd0;
    end else begin
      r_hdr_err <= w_hdr_bad;
      if ((w_hdr_bad || (r_state == ST_ABORT)) && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
    end
  end

  // Atomic commit of the channels addressed by the opcode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      red       <= 8'd0;
      green     <= 8'd0;
      blue      <= 8'd0;
      white     <= 8'd0;
      intensity <= INTENSITY_RST;
    end else if (r_state == ST_COMMIT) begin
      case (r_op)
        4'd1: begin
          red   <= r_shadow[0];
          green <= r_shadow[1];
          blue  <= r_shadow[2];
          white <= r_shadow[3];
        end
        4'd2: red       <= r_shadow[0];
        4'd3: green     <= r_shadow[0];
        4'd4: blue      <= r_shadow[0];
        4'd5: white     <= r_shadow[0];
        4'd6: intensity <= r_shadow[0];
        4'd7: begin
          red       <= r_shadow[0];
          green     <= r_shadow[1];
          blue      <= r_shadow[2];
          white     <= r_shadow[3];
          intensity <= r_shadow[4];
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_rgbw_frame_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_rgbw_frame_decoder
//  Brief    : Directed self-checking bench for spi_rgbw_frame_decoder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_rgbw_frame_decoder;

  logic       clk;
  logic       reset;
  logic       cs;
  logic       rdy;
  logic [7:0] data;
  logic [7:0] red, green, blue, white, intensity, err_count;
  logic       update, frame_err, busy;

  int checks = 0;
  int passes = 0;
  int n_upd  = 0;
  int n_err  = 0;
  int both   = 0;
  int upd0, err0, err_seen;

  spi_rgbw_frame_decoder #(
    .TIMEOUT_CYCLES(16),
    .INTENSITY_RST (8'hFF),
    .SYNC_NIBBLE   (4'hA)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .rdy       (rdy),
    .data      (data),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .white     (white),
    .intensity (intensity),
    .update    (update),
    .frame_err (frame_err),
    .err_count (err_count),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (update)              n_upd++;
    if (frame_err)           n_err++;
    if (update && frame_err) both = 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present one byte with rdy held high for 'hold' cycles.
  task automatic send_byte(input logic [7:0] b, input int hold);
    @(posedge clk); #1;
    data = b;
    rdy  = 1'b1;
    repeat (hold) @(posedge clk);
    #1 rdy = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; cs = 1'b1; rdy = 1'b0; data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_red", red, 8'h00);
    check("rst_white", white, 8'h00);
    check("rst_int", intensity, 8'hFF);
    check("rst_errcnt", err_count, 8'h00);
    check("rst_flags", {update, frame_err, busy}, 3'b000);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 cs = 1'b0;

    // 1) full RGBW frame with exact commit latency
    upd0 = n_upd;
    send_byte(8'hA1, 1); send_byte(8'h10, 1); send_byte(8'h20, 1);
    send_byte(8'h30, 1); send_byte(8'h40, 1);
    @(negedge clk);
    check("t1_update_pulse", update, 1'b1);
    check("t1_red_not_yet", red, 8'h00);
    @(negedge clk);
    check("t1_update_gone", update, 1'b0);
    check("t1_rgbw", {red, green, blue, white}, 32'h10203040);
    check("t1_int", intensity, 8'hFF);
    check("t1_errcnt", err_count, 8'h00);
    settle();
    check("t1_upd_count", n_upd - upd0, 1);

    // 2) single green, rdy held two cycles per byte
    upd0 = n_upd;
    send_byte(8'hA3, 2); send_byte(8'h7F, 2);
    settle();
    check("t2_rgbw", {red, green, blue, white}, 32'h107F3040);
    check("t2_upd_count", n_upd - upd0, 1);

    // 3) bad headers
    err0 = n_err; upd0 = n_upd;
    send_byte(8'h55, 1); send_byte(8'hA0, 1); send_byte(8'hAF, 1);
    settle();
    check("t3_err_pulses", n_err - err0, 3);
    check("t3_errcnt", err_count, 8'd3);
    check("t3_busy", busy, 1'b0);
    check("t3_rgbw", {red, green, blue, white}, 32'h107F3040);
    check("t3_no_update", n_upd - upd0, 0);

    // 4a) chip-select abort mid-frame
    err0 = n_err;
    send_byte(8'hA1, 1); send_byte(8'h11, 1); send_byte(8'h22, 1);
    @(posedge clk); #1 cs = 1'b1;
    settle();
    check("t4a_errcnt", err_count, 8'd4);
    check("t4a_err_pulses", n_err - err0, 1);
    check("t4a_rgbw", {red, green, blue, white}, 32'h107F3040);
    @(posedge clk); #1 cs = 1'b0;

    // 4b) cs rises together with the third byte
    upd0 = n_upd;
    send_byte(8'hA1, 1); send_byte(8'h11, 1);
    @(posedge clk); #1;
    data = 8'h22; rdy = 1'b1; cs = 1'b1;
    @(posedge clk); #1 rdy = 1'b0;
    settle();
    check("t4b_errcnt", err_count, 8'd5);
    check("t4b_rgbw", {red, green, blue, white}, 32'h107F3040);
    check("t4b_no_update", n_upd - upd0, 0);
    @(posedge clk); #1 cs = 1'b0;

    // 5) inter-byte timeout of 16 idle cycles
    send_byte(8'hA7, 1); send_byte(8'h01, 1);
    err_seen = 0;
    repeat (16) begin
      @(negedge clk);
      if (frame_err) err_seen = 1;
    end
    check("t5_no_early_err", err_seen, 0);
    check("t5_busy_waiting", busy, 1'b1);
    @(negedge clk);
    check("t5_timeout_err", frame_err, 1'b1);
    settle();
    check("t5_errcnt", err_count, 8'd6);
    check("t5_rgbw_held", {red, green, blue, white, intensity}, 40'h107F3040FF);
    send_byte(8'hA7, 1); send_byte(8'h01, 1); send_byte(8'h02, 1);
    send_byte(8'h03, 1); send_byte(8'h04, 1); send_byte(8'h05, 1);
    settle();
    check("t5_all", {red, green, blue, white, intensity}, 40'h0102030405);

    // 6) counter saturation, then reset mid-frame
    for (int i = 0; i < 300; i++) send_byte(8'h00, 1);
    settle();
    check("t6_saturate", err_count, 8'hFF);
    send_byte(8'hA1, 1); send_byte(8'h11, 1);
    check("t6_busy_before", busy, 1'b1);
    #2 reset = 1'b0;
    @(negedge clk);
    check("t6_rst_outputs", {red, green, blue, white, intensity}, 40'h00000000FF);
    check("t6_rst_errcnt", err_count, 8'h00);
    check("t6_rst_busy", busy, 1'b0);
    @(posedge clk); #1 reset = 1'b1;

    // recovery after reset
    send_byte(8'hA2, 1); send_byte(8'h5A, 1);
    settle();
    check("t7_red", red, 8'h5A);
    check("t7_errcnt", err_count, 8'h00);
    check("never_both", both, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
